// File: rtl/multi_driver_arbiter.sv
// multi_driver_arbiter: N request channels share one registered result.
// One channel wins per cycle (fixed priority or round-robin, with bounded
// lock retention); its operands are combined by its own op and registered.
// A saturating counter tracks cycles with more than one requester.
module multi_driver_arbiter #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDW     = $clog2(N_CH)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [N_CH-1:0]         req_in,
  input  logic [N_CH-1:0]         lock_in,
  input  logic [N_CH*WIDTH-1:0]   a_in,
  input  logic [N_CH*WIDTH-1:0]   b_in,
  input  logic [N_CH*2-1:0]       op_in,
  input  logic                    prio_mode_in,
  input  logic                    clr_in,
  output logic [WIDTH-1:0]        y_out,
  output logic                    y_valid_out,
  output logic [N_CH-1:0]         gnt_out,
  output logic [IDW-1:0]          src_id_out,
  output logic [CNT_W-1:0]        conflict_cnt_out
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDW:0]      NCH_L    = (IDW+1)'(N_CH);

  typedef logic [IDW-1:0] id_t;
  typedef enum logic [1:0] {
    OP_NOT = 2'd0,
    OP_XOR = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  // Registered state
  logic [WIDTH-1:0]  y_q;
  logic              valid_q;
  logic [N_CH-1:0]   gnt_q;
  id_t               src_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              own_vld_q;
  id_t               own_id_q;
  logic [HOLD_W-1:0] hold_q;
  id_t               rr_ptr_q;

  // Combinational arbitration results
  logic              keep_d;
  logic              found_d;
  id_t               win_d;
  logic [N_CH-1:0]   cand_d;
  logic [N_CH-1:0]   own_oh;
  logic [WIDTH-1:0]  res_d;
  logic [N_CH-1:0]   gnt_d;
  logic              contend_d;

  // Per-channel operand unpacking
  logic [WIDTH-1:0]  a_arr  [N_CH];
  logic [WIDTH-1:0]  b_arr  [N_CH];
  op_t               op_arr [N_CH];

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_unpack
    assign a_arr[g]  = a_in[g*WIDTH +: WIDTH];
    assign b_arr[g]  = b_in[g*WIDTH +: WIDTH];
    assign op_arr[g] = op_t'(op_in[g*2 +: 2]);
  end

  assign own_oh    = N_CH'(1) << own_id_q;
  assign contend_d = $countones(req_in) > 1;

  // Pick the winner: locked owner retention, else fixed/RR search with the
  // owner masked out once its hold budget is spent and someone else waits.
  always_comb begin
    logic [IDW:0] idx;
    keep_d  = 1'b0;
    found_d = 1'b0;
    win_d   = '0;
    cand_d  = req_in;
    idx     = '0;
    if (own_vld_q && req_in[own_id_q] && lock_in[own_id_q] && (hold_q < HOLD_MAX)) begin
      keep_d  = 1'b1;
      found_d = 1'b1;
      win_d   = own_id_q;
    end else begin
      if (own_vld_q && (hold_q == HOLD_MAX) && ((req_in & ~own_oh) != '0)) begin
        cand_d = req_in & ~own_oh;
      end
      if (prio_mode_in) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (!found_d && cand_d[id_t'(i)]) begin
            found_d = 1'b1;
            win_d   = id_t'(i);
          end
        end
      end else begin
        for (int unsigned k = 1; k <= N_CH; k++) begin
          idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
          if (idx >= NCH_L) idx = idx - NCH_L;
          if (!found_d && cand_d[idx[IDW-1:0]]) begin
            found_d = 1'b1;
            win_d   = idx[IDW-1:0];
          end
        end
      end
    end
  end

  // Apply the winner's op to its operands
  always_comb begin
    res_d = '0;
    gnt_d = '0;
    unique case (op_arr[win_d])
      OP_NOT:  res_d = ~a_arr[win_d];
      OP_XOR:  res_d = a_arr[win_d] ^ b_arr[win_d];
      OP_AND:  res_d = a_arr[win_d] & b_arr[win_d];
      OP_OR:   res_d = a_arr[win_d] | b_arr[win_d];
      default: res_d = '0;
    endcase
    if (found_d) gnt_d = N_CH'(1) << win_d;
  end

  // Register outputs, ownership, hold count, RR pointer and conflict counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_q       <= '0;
      valid_q   <= 1'b0;
      gnt_q     <= '0;
      src_q     <= '0;
      cnt_q     <= '0;
      own_vld_q <= 1'b0;
      own_id_q  <= '0;
      hold_q    <= '0;
      rr_ptr_q  <= id_t'(N_CH - 1);
    end else begin
      if (clr_in) begin
        cnt_q <= '0;
      end else if (contend_d && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (found_d) begin
        y_q       <= res_d;
        valid_q   <= 1'b1;
        gnt_q     <= gnt_d;
        src_q     <= win_d;
        own_vld_q <= 1'b1;
        own_id_q  <= win_d;
        hold_q    <= keep_d ? hold_q + 1'b1 : HOLD_W'(1);
        rr_ptr_q  <= win_d;
      end else begin
        valid_q   <= 1'b0;
        gnt_q     <= '0;
        own_vld_q <= 1'b0;
        hold_q    <= '0;
      end
    end
  end

  assign y_out            = y_q;
  assign y_valid_out      = valid_q;
  assign gnt_out          = gnt_q;
  assign src_id_out       = src_q;
  assign conflict_cnt_out = cnt_q;

endmodule

// File: tb/tb_multi_driver_arbiter.sv
// Testbench for multi_driver_arbiter: directed steps from the test plan plus
// a random phase, all checked against a behavioural reference model.
module tb_multi_driver_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_in, lock_in;
  logic [N*W-1:0] a_in, b_in;
  logic [N*2-1:0] op_in;
  logic           prio, clr;
  logic [W-1:0]   y_out;
  logic           y_valid_out;
  logic [N-1:0]   gnt_out;
  logic [1:0]     src_id_out;
  logic [CW-1:0]  cnt_out;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int           m_owner, m_hold, m_rr, m_cnt, m_src;
  logic [W-1:0] m_y;
  bit           m_valid;
  logic [N-1:0] m_gnt;

  multi_driver_arbiter #(.N_CH(N), .WIDTH(W), .MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req_in), .lock_in(lock_in),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .prio_mode_in(prio), .clr_in(clr),
    .y_out(y_out), .y_valid_out(y_valid_out), .gnt_out(gnt_out),
    .src_id_out(src_id_out), .conflict_cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_rr = N - 1; m_cnt = 0; m_src = 0;
    m_y = '0; m_valid = 0; m_gnt = '0;
  endtask

  // One clock of the arbitration rules, evaluated on the current inputs
  task automatic model_step();
    int win = -1;
    bit keep = 0;
    logic [N-1:0] cand = req_in;
    logic [W-1:0] a, b;
    logic [1:0] op;
    if (m_owner >= 0 && ((req_in >> m_owner) & 1) != 0 && ((lock_in >> m_owner) & 1) != 0
        && m_hold < MH) begin
      win = m_owner; keep = 1;
    end else begin
      if (m_owner >= 0 && m_hold == MH && (req_in & ~(N'(1) << m_owner)) != 0)
        cand = cand & ~(N'(1) << m_owner);
      if (prio) begin
        for (int i = 0; i < N; i++) if (win < 0 && ((cand >> i) & 1) != 0) win = i;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int idx = (m_rr + k) % N;
          if (win < 0 && ((cand >> idx) & 1) != 0) win = idx;
        end
      end
    end
    if (clr) m_cnt = 0;
    else if ($countones(req_in) > 1 && m_cnt < (1 << CW) - 1) m_cnt++;
    if (win >= 0) begin
      a  = W'(a_in >> (win * W));
      b  = W'(b_in >> (win * W));
      op = 2'(op_in >> (win * 2));
      case (op)
        2'd0: m_y = ~a;
        2'd1: m_y = a ^ b;
        2'd2: m_y = a & b;
        default: m_y = a | b;
      endcase
      m_valid = 1; m_gnt = N'(1) << win; m_src = win;
      m_hold  = keep ? m_hold + 1 : 1;
      m_owner = win; m_rr = win;
    end else begin
      m_valid = 0; m_gnt = '0; m_owner = -1; m_hold = 0;
    end
  endtask

  // Advance one clock and compare every output with the model
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    chk("y", y_out, m_y);
    chk("valid", y_valid_out, m_valid);
    chk("gnt", gnt_out, m_gnt);
    chk("src", src_id_out, m_src);
    chk("cnt", cnt_out, m_cnt);
    chk("inv_onehot0", $onehot0(gnt_out), 1);
    chk("inv_valid_gnt", y_valid_out, |gnt_out);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op);
    a_in[ch*W +: W] = a;
    b_in[ch*W +: W] = b;
    op_in[ch*2 +: 2] = op;
  endtask

  int exp3 [6] = '{0, 1, 3, 0, 1, 3};
  int exp4 [6] = '{1, 1, 1, 1, 3, 1};
  logic [W-1:0] exp5 [4] = '{8'h5A, 8'hAA, 8'h05, 8'hAF};

  initial begin
    req_in = '0; lock_in = '0; a_in = '0; b_in = '0; op_in = '0;
    prio = 1'b0; clr = 1'b0; rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_y", y_out, 0);
    chk("rst_valid", y_valid_out, 0);
    chk("rst_gnt", gnt_out, 0);
    chk("rst_src", src_id_out, 0);
    chk("rst_cnt", cnt_out, 0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Single source
    req_in = 4'b0100; set_ch(2, 8'hF0, 8'h3C, 2'd1);
    cyc();
    chk("t1_y", y_out, 8'hCC);
    chk("t1_gnt", gnt_out, 4'b0100);
    chk("t1_src", src_id_out, 2);
    chk("t1_cnt", cnt_out, 0);

    // 2. Fixed priority
    do_reset();
    req_in = 4'b1111; prio = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_gnt", gnt_out, 4'b0001);
    end
    chk("t2_cnt", cnt_out, 3);

    // 3. Round-robin from reset
    do_reset();
    req_in = 4'b1011; prio = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_src", src_id_out, exp3[i]);
    end

    // 4. Lock with forced release, then sole locked owner
    do_reset();
    req_in = 4'b1010; lock_in = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t4_src", src_id_out, exp4[i]);
    end
    req_in = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t4_solo_gnt", gnt_out, 4'b0010);
    end
    lock_in = '0;

    // 5. Ops and idle hold
    do_reset();
    req_in = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 8'hA5, 8'h0F, 2'(i));
      cyc();
      chk("t5_y", y_out, exp5[i]);
    end
    req_in = '0;
    cyc();
    chk("t5_idle_valid", y_valid_out, 0);
    chk("t5_idle_y", y_out, 8'hAF);

    // 6. Counter saturation, clear under contention, async reset mid-grant
    do_reset();
    req_in = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("t6_cnt", cnt_out, (i + 1 < 7) ? i + 1 : 7);
    end
    clr = 1'b1;
    cyc();
    chk("t6_clr", cnt_out, 0);
    clr = 1'b0;
    cyc();
    chk("t6_grant_before_rst", y_valid_out, 1);
    #2; rst_n = 1'b0; model_reset();
    #1;
    chk("t6_arst_y", y_out, 0);
    chk("t6_arst_valid", y_valid_out, 0);
    chk("t6_arst_gnt", gnt_out, 0);
    chk("t6_arst_src", src_id_out, 0);
    chk("t6_arst_cnt", cnt_out, 0);
    @(posedge clk); #3; rst_n = 1'b1;

    // Random phase against the model
    for (int c = 0; c < 400; c++) begin
      req_in  = N'($urandom);
      if ($urandom_range(0, 7) == 0) req_in = '0;
      lock_in = N'($urandom) | N'($urandom);
      a_in    = $urandom;
      b_in    = $urandom;
      op_in   = 8'($urandom);
      if ($urandom_range(0, 9) == 0) prio = ~prio;
      clr     = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
